// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: WIDTH bits split into STAGES chunks, one chunk summed per clock.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int CHUNK = WIDTH / STAGES;

   logic             advance;

   logic [STAGES-1:0] vld_d, vld_q;
   logic [WIDTH-1:0]  opa_d [STAGES];
   logic [WIDTH-1:0]  opa_q [STAGES];
   logic [WIDTH-1:0]  opb_d [STAGES];
   logic [WIDTH-1:0]  opb_q [STAGES];
   logic [WIDTH-1:0]  acc_d [STAGES];
   logic [WIDTH-1:0]  acc_q [STAGES];
   logic              cy_d  [STAGES];
   logic              cy_q  [STAGES];

   logic              src_v [STAGES];
   logic [WIDTH-1:0]  src_a [STAGES];
   logic [WIDTH-1:0]  src_b [STAGES];
   logic [WIDTH-1:0]  src_s [STAGES];
   logic              src_c [STAGES];
   logic [CHUNK:0]    part  [STAGES];

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_d, ovf_q;
   logic cy_into_msb;
`endif

   assign advance   = !vld_q[STAGES-1] || out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_q[STAGES-1];
   assign sum       = acc_q[STAGES-1];
   assign cout      = cy_q[STAGES-1];
`ifdef PIPELINED_ADDER_OVF_EN
   assign ovf       = ovf_q;
`endif

   // Operands shift down one chunk per stage so the active chunk always sits at the LSBs;
   // partial sums enter at the top and shift down, landing in place after the last stage.
   always_comb begin
      src_v[0] = in_valid;
      src_a[0] = x;
      src_b[0] = sub ? ~y : y;
      src_c[0] = sub ? ~cin : cin;
      src_s[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k] = vld_q[k-1];
         src_a[k] = opa_q[k-1];
         src_b[k] = opb_q[k-1];
         src_c[k] = cy_q[k-1];
         src_s[k] = acc_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part[k] = {1'b0, src_a[k][CHUNK-1:0]} + {1'b0, src_b[k][CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, src_c[k]};
      end
   end

   always_comb begin
      vld_d = vld_q;
      for (int k = 0; k < STAGES; k++) begin
         opa_d[k] = opa_q[k];
         opb_d[k] = opb_q[k];
         acc_d[k] = acc_q[k];
         cy_d[k]  = cy_q[k];
         if (advance) begin
            vld_d[k] = src_v[k];
            opa_d[k] = src_a[k] >> CHUNK;
            opb_d[k] = src_b[k] >> CHUNK;
            acc_d[k] = (src_s[k] >> CHUNK)
                     | (WIDTH'(part[k][CHUNK-1:0]) << (WIDTH - CHUNK));
            cy_d[k]  = part[k][CHUNK];
         end
      end
   end

`ifdef PIPELINED_ADDER_OVF_EN
   // In the last stage the top chunk sits at the LSBs, so its MSB is bit CHUNK-1.
   always_comb begin
      cy_into_msb = part[STAGES-1][CHUNK-1] ^ src_a[STAGES-1][CHUNK-1]
                  ^ src_b[STAGES-1][CHUNK-1];
      ovf_d       = advance ? (cy_into_msb ^ part[STAGES-1][CHUNK]) : ovf_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            opa_q[k] <= '0;
            opb_q[k] <= '0;
            acc_q[k] <= '0;
            cy_q[k]  <= 1'b0;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < STAGES; k++) begin
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
            acc_q[k] <= acc_d[k];
            cy_q[k]  <= cy_d[k];
         end
      end
   end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the team's ripple-carry adder chain (half_adder -> full_adder -> 4-bit adder).
- Splits a WIDTH-bit operation into STAGES equal chunks, one chunk per clock. The carry is registered between stages, so the critical path is one CHUNK-bit ripple.
- Valid/ready handshake on both sides. Used wherever a wide adder must close timing at full clock rate with backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES
- STAGES, 4, pipeline depth (1..WIDTH); CHUNK = WIDTH/STAGES bits summed per stage

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts beat this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: x+y+cin; 1: x-y-cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  add: carry-out; sub: 1 = no borrow (x >= y+cin unsigned)

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous, active-low. Sampled only on the rising edge of clk.
- Reset (rst_n=0 at an edge): all stage valid bits cleared; out_valid=0, sum=0, cout=0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded and none is ever output.
- Transfer rule: a beat is accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
- Operand conditioning at accept: yy = sub ? ~y : y; c0 = sub ? ~cin : cin.
- Stage k (0..STAGES-1):
  - adds chunk k of x and yy plus the carry from stage k-1 (c0 for k=0);
  - registers the CHUNK-bit partial sum and the carry;
  - carries the not-yet-summed upper chunks forward, skewed, with its valid bit.
- Lower result chunks are held in the stage registers until the last stage. sum and cout are registered outputs of stage STAGES-1.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles through the register chain. Throughput is 1 beat/cycle with no bubbles while out_ready=1.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0 every stage register holds, including bubbles.
  - in_ready is combinational from out_ready and out_valid only, never from in_valid.
- Bubbles: a stage whose valid=0 may hold any data, but valid must propagate correctly. out_valid is asserted only for accepted beats, in order.
- sum/cout stay stable while out_valid=1 && out_ready=0.
- Simultaneous accept and deliver in one cycle is legal; occupancy is unchanged.
- Wrap-around: sum is modulo 2^WIDTH with no saturation. Examples: 0xFFFF+0x0001 gives sum=0x0000, cout=1. Subtract 0x0000-0x0001 gives sum=0xFFFF, cout=0.
- STAGES=1: pure registered adder, latency 1.

Optional Feature:
- Macro PIPELINED_ADDER_OVF_EN.
- When defined:
  - adds output ovf (1 bit, registered, aligned with sum) = signed two's-complement overflow;
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage;
  - ovf resets to 0 and holds under stall like sum.
- When undefined: no ovf port and no extra logic; all other behaviour is identical.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0 throughout. in_ready=1 the cycle after release.
- Latency/add (WIDTH=16, STAGES=4, out_ready=1): x=0x1234, y=0x4321, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x5555, cout=0.
- Carry across all chunks: x=0xFFFF, y=0x0000, cin=1 -> sum=0x0000, cout=1.
- Subtract: x=0x0005, y=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0. With OVF_EN: x=0x8000, y=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Backpressure: stream 8 back-to-back beats x=i, y=i (i=0..7); hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, no beat lost or duplicated, outputs 0,2,4,...,14 in order, sum stable while stalled.
- Reset mid-stream: 3 beats in flight, rst_n=0 for one edge -> none emerge; the next accepted beat x=1, y=1 yields sum=2 after 4 cycles.
